render_sequencer: RTL and testbench

- Control FSM that drives the note-highway datapath:
  - paints the 240x180 default image once;
  - then, once per frame tick, shifts the song by one step and repaints the 12 note boxes (3 lanes x 4 boxes, each 60x60).
- Generates every datapath strobe and counter (gridCounter, boxCounter, pixelCount), aligns write strobes to the datapath pipeline latency, and produces the VGA plot enable.

---
 rtl/render_pkg.sv | 30 +++
 rtl/render_sequencer_if.sv | 39 +++
 rtl/strobe_delay.sv | 30 +++
 rtl/render_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_render_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/render_pkg.sv
// Shared state encoding, default geometry and field-packing helpers for the
// note-highway render sequencer.
package render_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEFAULT,
        DRAIN_D,
        WAIT,
        SHIFT,
        SETUP,
        PIXEL,
        DRAIN_B,
        DONE
    } state_e;

    localparam int GRID_W_DEF    = 240;
    localparam int GRID_H_DEF    = 180;
    localparam int BOX_SIZE_DEF  = 60;
    localparam int NUM_BOXES_DEF = 12;

    function automatic logic [15:0] pack_grid(input logic [7:0] x, input logic [7:0] y);
        return {x, y};
    endfunction

    function automatic logic [14:0] pack_pixel(input logic [7:0] x, input logic [6:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/render_sequencer_if.sv
// Control bundle between the render sequencer (master) and the note-highway
// datapath / VGA plotter (slave).
interface render_sequencer_if;
    import render_pkg::*;

    // Every output is a registered level or single-cycle strobe; start is a
    // one-cycle pulse that is only acted on while the sequencer is idle.
    logic        start;
    logic        shiftSong;
    logic        loadStartAddress;
    logic        loadX;
    logic        loadY;
    logic        writeToScreen;
    logic        loadDefault;
    logic        writeDefault;
    logic        songDone;
    logic [15:0] gridCounter;
    logic [3:0]  boxCounter;
    logic [14:0] pixelCount;
    logic        plot;
    logic        busy;
    logic        tickOverrun;
    state_e      dbg_state;

    modport master (
        input  start,
        output shiftSong, loadStartAddress, loadX, loadY, writeToScreen,
               loadDefault, writeDefault, songDone, gridCounter, boxCounter,
               pixelCount, plot, busy, tickOverrun, dbg_state
    );

    modport slave (
        output start,
        input  shiftSong, loadStartAddress, loadX, loadY, writeToScreen,
               loadDefault, writeDefault, songDone, gridCounter, boxCounter,
               pixelCount, plot, busy, tickOverrun, dbg_state
    );

endinterface

// File: rtl/strobe_delay.sv
// Fixed-latency strobe pipeline; clears asynchronously so no stale pulse
// survives a reset.
module strobe_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/render_sequencer.sv
// Control FSM for the note-highway datapath: paints the default image once,
// then on every frame tick shifts the song and repaints the note boxes.
module render_sequencer
    import render_pkg::*;
#(
    parameter int GRID_W      = GRID_W_DEF,
    parameter int GRID_H      = GRID_H_DEF,
    parameter int BOX_SIZE    = BOX_SIZE_DEF,
    parameter int NUM_BOXES   = NUM_BOXES_DEF,
    parameter int SONG_LEN    = 115,
    parameter int TICK_CYCLES = 12500000,
    parameter int DEF_LAT     = 2,
    parameter int BOX_LAT     = 2,
    parameter int SETUP_CYC   = 2
) (
    input  logic                clock,
    input  logic                reset,
    render_sequencer_if.master  bus
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam int SW = $clog2(SONG_LEN + 1);
    localparam int CW = 4;

    state_e          state_q, state_d;
    logic [7:0]      gx_q, gx_d, gy_q, gy_d, px_q, px_d;
    logic [6:0]      py_q, py_d;
    logic [3:0]      box_q, box_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [SW-1:0]   shift_cnt_q, shift_cnt_d;
    logic            pending_q, pending_d, overrun_q, overrun_d;
    logic            shift_song_q, shift_song_d, load_start_q, load_start_d;
    logic            load_xy_q, load_xy_d, load_default_q, load_default_d;
    logic            song_done_q, song_done_d, busy_q, busy_d;
    logic            running, tick;
    logic            write_screen, write_default, plot_w;

    always_comb begin
        state_d     = state_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        px_d        = px_q;
        py_d        = py_q;
        box_d       = box_q;
        cnt_d       = cnt_q;
        shift_cnt_d = shift_cnt_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        // The frame timer only runs once the default image is finished.
        running     = !(state_q inside {IDLE, DEFAULT, DRAIN_D});
        tick        = running && (tick_q == TW'(TICK_CYCLES - 1));
        tick_d      = tick ? '0 : tick_q + 1'b1;
        if (!running) begin
            tick_d    = '0;
            pending_d = 1'b0;
        end else if (tick) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DEFAULT;
                    gx_d    = '0;
                    gy_d    = '0;
                end
            end
            DEFAULT: begin
                if (gy_q == 8'(GRID_H - 1)) begin
                    if (gx_q == 8'(GRID_W - 1)) begin
                        state_d = DRAIN_D;
                        cnt_d   = '0;
                    end else begin
                        gx_d = gx_q + 1'b1;
                        gy_d = '0;
                    end
                end else begin
                    gy_d = gy_q + 1'b1;
                end
            end
            DRAIN_D: begin
                if (cnt_q == CW'(DEF_LAT - 1)) begin
                    state_d     = WAIT;
                    shift_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (tick || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = (shift_cnt_q == SW'(SONG_LEN)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shift_cnt_d = shift_cnt_q + 1'b1;
                box_d       = 4'd1;
                cnt_d       = '0;
                px_d        = '0;
                py_d        = '0;
                state_d     = SETUP;
            end
            SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) state_d = PIXEL;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            PIXEL: begin
                if (py_q == 7'(BOX_SIZE - 1)) begin
                    if (px_q == 8'(BOX_SIZE - 1)) begin
                        state_d = DRAIN_B;
                        cnt_d   = '0;
                    end else begin
                        px_d = px_q + 1'b1;
                        py_d = '0;
                    end
                end else begin
                    py_d = py_q + 1'b1;
                end
            end
            DRAIN_B: begin
                if (cnt_q == CW'(BOX_LAT - 1)) begin
                    if (box_q == 4'(NUM_BOXES)) begin
                        box_d   = '0;
                        state_d = WAIT;
                    end else begin
                        box_d   = box_q + 1'b1;
                        cnt_d   = '0;
                        px_d    = '0;
                        py_d    = '0;
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they register in step with it.
        load_default_d = (state_d == DEFAULT);
        shift_song_d   = (state_d == SHIFT);
        load_start_d   = (state_d == SETUP);
        load_xy_d      = (state_d == PIXEL);
        song_done_d    = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            gx_q           <= '0;
            gy_q           <= '0;
            px_q           <= '0;
            py_q           <= '0;
            box_q          <= '0;
            cnt_q          <= '0;
            tick_q         <= '0;
            shift_cnt_q    <= '0;
            pending_q      <= 1'b0;
            overrun_q      <= 1'b0;
            shift_song_q   <= 1'b0;
            load_start_q   <= 1'b0;
            load_xy_q      <= 1'b0;
            load_default_q <= 1'b0;
            song_done_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gx_q           <= gx_d;
            gy_q           <= gy_d;
            px_q           <= px_d;
            py_q           <= py_d;
            box_q          <= box_d;
            cnt_q          <= cnt_d;
            tick_q         <= tick_d;
            shift_cnt_q    <= shift_cnt_d;
            pending_q      <= pending_d;
            overrun_q      <= overrun_d;
            shift_song_q   <= shift_song_d;
            load_start_q   <= load_start_d;
            load_xy_q      <= load_xy_d;
            load_default_q <= load_default_d;
            song_done_q    <= song_done_d;
            busy_q         <= busy_d;
        end
    end

    strobe_delay #(.DEPTH(BOX_LAT)) u_dly_screen (
        .clk(clock), .rst_n(reset), .d(load_xy_q), .q(write_screen)
    );
    strobe_delay #(.DEPTH(DEF_LAT)) u_dly_default (
        .clk(clock), .rst_n(reset), .d(load_default_q), .q(write_default)
    );
    strobe_delay #(.DEPTH(1)) u_dly_plot (
        .clk(clock), .rst_n(reset), .d(write_screen | write_default), .q(plot_w)
    );

    assign bus.shiftSong        = shift_song_q;
    assign bus.loadStartAddress = load_start_q;
    assign bus.loadX            = load_xy_q;
    assign bus.loadY            = load_xy_q;
    assign bus.writeToScreen    = write_screen;
    assign bus.loadDefault      = load_default_q;
    assign bus.writeDefault     = write_default;
    assign bus.songDone         = song_done_q;
    assign bus.gridCounter      = pack_grid(gx_q, gy_q);
    assign bus.boxCounter       = box_q;
    assign bus.pixelCount       = pack_pixel(px_q, py_q);
    assign bus.plot             = plot_w;
    assign bus.busy             = busy_q;
    assign bus.tickOverrun      = overrun_q;
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer: three instances share one clock, each
// sized so its scenario completes quickly (full image, full frame, fast ticks).
module tb_render_sequencer;
    import render_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    render_sequencer_if ia();
    render_sequencer_if ib();
    render_sequencer_if ic();

    // A: full 240x180 image.  B: tiny image, full 12 x 60x60 frame, ticks shorter
    // than a frame.  C: tiny boxes and very fast ticks, three-step song.
    render_sequencer #(.TICK_CYCLES(50000), .SONG_LEN(3)) u_a (
        .clock(clk), .reset(rst_a), .bus(ia)
    );
    render_sequencer #(.GRID_W(2), .GRID_H(3), .TICK_CYCLES(20000), .SONG_LEN(1)) u_b (
        .clock(clk), .reset(rst_b), .bus(ib)
    );
    render_sequencer #(.GRID_W(2), .GRID_H(3), .BOX_SIZE(4), .TICK_CYCLES(100), .SONG_LEN(3)) u_c (
        .clock(clk), .reset(rst_c), .bus(ic)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- monitor A ----------------
    int          a_wd, a_ld, a_err;
    logic [15:0] a_first_gc, a_last_gc;
    logic        a_seen, a_wr_h;
    logic [1:0]  a_ld_h;

    always @(negedge clk) begin
        if (!rst_a) begin
            a_ld_h <= '0; a_wr_h <= 1'b0; a_seen <= 1'b0; a_wd <= 0; a_ld <= 0;
        end else begin
            if (ia.writeDefault !== a_ld_h[1] || ia.plot !== a_wr_h ||
                (ia.writeDefault && ia.writeToScreen) || ia.loadX !== ia.loadY)
                a_err <= a_err + 1;
            if (ia.writeDefault) a_wd <= a_wd + 1;
            if (ia.loadDefault) begin
                a_ld      <= a_ld + 1;
                a_last_gc <= ia.gridCounter;
                if (!a_seen) a_first_gc <= ia.gridCounter;
                a_seen    <= 1'b1;
            end
            a_ld_h <= {a_ld_h[0], ia.loadDefault};
            a_wr_h <= ia.writeDefault | ia.writeToScreen;
        end
    end

    // ---------------- monitor B ----------------
    int          b_wts[16];
    logic [14:0] b_last_pc[16];
    int          b_shift, b_done, b_err;
    logic [1:0]  b_lx_h;
    logic        b_wr_h;

    always @(negedge clk) begin
        if (!rst_b) begin
            b_lx_h <= '0; b_wr_h <= 1'b0;
        end else begin
            if (ib.writeToScreen !== b_lx_h[1] || ib.plot !== b_wr_h ||
                (ib.writeDefault && ib.writeToScreen) || ib.loadX !== ib.loadY)
                b_err <= b_err + 1;
            if (ib.writeToScreen) b_wts[ib.boxCounter] <= b_wts[ib.boxCounter] + 1;
            if (ib.loadX) b_last_pc[ib.boxCounter] <= ib.pixelCount;
            if (ib.shiftSong) b_shift <= b_shift + 1;
            if (ib.songDone) b_done <= b_done + 1;
            b_lx_h <= {b_lx_h[0], ib.loadX};
            b_wr_h <= ib.writeDefault | ib.writeToScreen;
        end
    end

    // ---------------- monitor C ----------------
    logic [3:0]  c_obs_q[$];
    logic [3:0]  exp_q[$];
    logic [3:0]  c_box_prev;
    logic [14:0] c_last_pc[16];
    state_e      c_st1, c_st2;
    int          c_wts, c_shift, c_done, c_imm, c_done_imm, c_lsa, c_err;
    logic [1:0]  c_lx_h;
    logic        c_wr_h;

    always @(negedge clk) begin
        if (!rst_c) begin
            c_lx_h <= '0; c_wr_h <= 1'b0; c_box_prev <= '0; c_st1 <= IDLE; c_st2 <= IDLE;
        end else begin
            if (ic.writeToScreen !== c_lx_h[1] || ic.plot !== c_wr_h ||
                (ic.writeDefault && ic.writeToScreen) || ic.loadX !== ic.loadY ||
                (ic.loadStartAddress && ic.pixelCount != 15'd0))
                c_err <= c_err + 1;
            if (ic.boxCounter != c_box_prev) c_obs_q.push_back(ic.boxCounter);
            if (ic.writeToScreen) c_wts <= c_wts + 1;
            if (ic.loadStartAddress) c_lsa <= c_lsa + 1;
            if (ic.loadX) c_last_pc[ic.boxCounter] <= ic.pixelCount;
            if (ic.shiftSong) c_shift <= c_shift + 1;
            if (ic.songDone) c_done <= c_done + 1;
            if (ic.shiftSong && c_st1 == WAIT && c_st2 == DRAIN_B) c_imm <= c_imm + 1;
            if (ic.songDone && c_st1 == WAIT && c_st2 == DRAIN_B) c_done_imm <= c_done_imm + 1;
            c_box_prev <= ic.boxCounter;
            c_st1      <= ic.dbg_state;
            c_st2      <= c_st1;
            c_lx_h     <= {c_lx_h[0], ic.loadX};
            c_wr_h     <= ic.writeDefault | ic.writeToScreen;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ia.start = 1'b0;
        ib.start = 1'b0;
        ic.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        @(negedge clk);
        check("rst_state", ia.dbg_state, IDLE);
        check("rst_busy", ia.busy, 0);
        check("rst_grid", ia.gridCounter, 0);
        check("rst_box", ia.boxCounter, 0);
        check("rst_pixel", ia.pixelCount, 0);
        check("rst_plot", ia.plot, 0);
        check("rst_overrun", ia.tickOverrun, 0);

        fork
            begin : run_a
                int n;
                ia.start = 1'b1; @(negedge clk); ia.start = 1'b0;
                for (n = 0; n < 2000 && ia.gridCounter !== 16'h0510; n++) @(negedge clk);
                check("a_reach_0510", n < 2000, 1);
                check("a_mid_load", ia.loadDefault, 1);
                #1 rst_a = 1'b0;
                #1;
                check("a_rst_busy", ia.busy, 0);
                check("a_rst_grid", ia.gridCounter, 0);
                check("a_rst_load", ia.loadDefault, 0);
                check("a_rst_wdef", ia.writeDefault, 0);
                check("a_rst_plot", ia.plot, 0);
                repeat (3) @(negedge clk);
                rst_a = 1'b1;
                repeat (4) @(negedge clk);
                check("a_post_state", ia.dbg_state, IDLE);
                check("a_post_busy", ia.busy, 0);
                check("a_post_wdef", a_wd, 0);

                ia.start = 1'b1; @(negedge clk); ia.start = 1'b0;
                for (n = 0; n < 45000 && ia.dbg_state != WAIT; n++) @(negedge clk);
                check("a_reach_wait", n < 45000, 1);
                repeat (3) @(negedge clk);
                check("a_wdef_count", a_wd, 43200);
                check("a_ldef_count", a_ld, 43200);
                check("a_first_grid", a_first_gc, 16'h0000);
                check("a_last_grid", a_last_gc, 16'hEFB3);
                check("a_lag_errors", a_err, 0);
                check("a_wait_busy", ia.busy, 1);
                check("a_wait_box", ia.boxCounter, 0);
            end
            begin : run_b
                int n;
                ib.start = 1'b1; @(negedge clk); ib.start = 1'b0;
                for (n = 0; n < 100 && ib.dbg_state != WAIT; n++) @(negedge clk);
                check("b_reach_wait", n < 100, 1);
                for (n = 0; n < 25000 && !ib.shiftSong; n++) @(negedge clk);
                check("b_tick_period", n, 20000);
                for (n = 0; n < 20000 && !(ib.boxCounter == 4'd3 && ib.pixelCount == 15'd5); n++)
                    @(negedge clk);
                check("b_reach_box3", n < 20000, 1);
                ib.start = 1'b1; @(negedge clk); ib.start = 1'b0;
                check("b_start_ign_box", ib.boxCounter, 3);
                check("b_start_ign_pix", ib.pixelCount, 6);
                check("b_start_ign_state", ib.dbg_state, PIXEL);
                for (n = 0; n < 60000 && !ib.songDone; n++) @(negedge clk);
                check("b_reach_done", n < 60000, 1);
                @(negedge clk);
                check("b_done_pulse", ib.songDone, 0);
                check("b_idle_busy", ib.busy, 0);
                check("b_idle_state", ib.dbg_state, IDLE);
                repeat (2) @(negedge clk);
                for (int k = 1; k <= 12; k++) begin
                    check($sformatf("b_wts_box%0d", k), b_wts[k], 3600);
                    check($sformatf("b_lastpc_box%0d", k), b_last_pc[k], 15'h1DBB);
                end
                check("b_shift_count", b_shift, 1);
                check("b_done_count", b_done, 1);
                check("b_overrun", ib.tickOverrun, 1);
                check("b_box_zero", ib.boxCounter, 0);
                check("b_lag_errors", b_err, 0);
            end
            begin : run_c
                int n;
                ic.start = 1'b1; @(negedge clk); ic.start = 1'b0;
                for (n = 0; n < 100 && ic.dbg_state != WAIT; n++) @(negedge clk);
                check("c_reach_wait", n < 100, 1);
                for (n = 0; n < 200 && !ic.shiftSong; n++) @(negedge clk);
                check("c_tick_period", n, 100);
                for (n = 0; n < 2000 && !ic.songDone; n++) @(negedge clk);
                check("c_reach_done", n < 2000, 1);
                @(negedge clk);
                check("c_idle_busy", ic.busy, 0);
                repeat (2) @(negedge clk);
                check("c_wts_total", c_wts, 576);
                check("c_shift_count", c_shift, 3);
                check("c_done_count", c_done, 1);
                check("c_imm_shift", c_imm, 2);
                check("c_imm_done", c_done_imm, 1);
                check("c_lsa_count", c_lsa, 72);
                check("c_overrun", ic.tickOverrun, 1);
                check("c_lag_errors", c_err, 0);
                for (int k = 1; k <= 12; k++)
                    check($sformatf("c_lastpc_box%0d", k), c_last_pc[k], 15'h0183);
                for (int f = 0; f < 3; f++) begin
                    for (int b = 1; b <= 12; b++) exp_q.push_back(4'(b));
                    exp_q.push_back(4'd0);
                end
                check("c_box_seq_len", c_obs_q.size(), 39);
                for (int k = 0; k < 39 && k < c_obs_q.size(); k++)
                    check($sformatf("c_box_seq%0d", k), c_obs_q[k], exp_q[k]);
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
